// File: rtl/serial_subtractor_if.sv
// Handshake/data bundle for the bit-serial subtractor.
// master: start, a, b, bin -> ; slave: busy, done, diff, bout, ovf ->
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, ovf
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: a - b - bin, one bit per clock, LSB first.
// Ports: clk, rst_n (sync, active-low), bus (slave side of serial_subtractor_if).
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_ovf;

    logic             w_ai;
    logic             w_bi;
    logic             w_d;
    logic             w_brn;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;
    logic             w_busy;
    logic             w_done;

    assign w_ai       = r_a[0];
    assign w_bi       = r_b[0];
    assign w_d        = w_ai ^ w_bi ^ r_br;
    assign w_brn      = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
    assign w_last     = (r_cnt == LAST);
    assign w_res_next = {w_d, r_res[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.start) w_next = S_SHIFT;
            S_SHIFT: if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        unique case (r_state)
            S_SHIFT: w_busy = 1'b1;
            S_DONE:  w_done = 1'b1;
            default: ;
        endcase
    end

    // On the last shift edge the operand registers hold only the
    // original MSBs in bit 0, and w_d is the result MSB.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_res  <= '0;
            r_br   <= 1'b0;
            r_cnt  <= '0;
            r_diff <= '0;
            r_bout <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a   <= bus.a;
                        r_b   <= bus.b;
                        r_br  <= bus.bin;
                        r_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_br  <= w_brn;
                    r_res <= w_res_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_diff <= w_res_next;
                        r_bout <= w_brn;
                        r_ovf  <= (w_ai != w_bi) && (w_d != w_ai);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = w_busy;
    assign bus.done = w_done;
    assign bus.diff = r_diff;
    assign bus.bout = r_bout;
    assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor at WIDTH=8 and WIDTH=13.
// Directed vectors, hand sequences, randomized ops vs arithmetic model.
module tb_serial_subtractor;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [63:0] prev_d [2];
    logic        prev_b [2];
    logic        prev_o [2];

    serial_subtractor_if #(.WIDTH(8))  if8 ();
    serial_subtractor_if #(.WIDTH(13)) if13 ();

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8.slave)
    );

    serial_subtractor #(.WIDTH(13)) u_dut13 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if13.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] g_diff(input int w);
        return (w == 8) ? 64'(if8.diff) : 64'(if13.diff);
    endfunction
    function automatic logic g_bout(input int w);
        return (w == 8) ? if8.bout : if13.bout;
    endfunction
    function automatic logic g_ovf(input int w);
        return (w == 8) ? if8.ovf : if13.ovf;
    endfunction
    function automatic logic g_busy(input int w);
        return (w == 8) ? if8.busy : if13.busy;
    endfunction
    function automatic logic g_done(input int w);
        return (w == 8) ? if8.done : if13.done;
    endfunction

    task automatic drive(input int w, input logic st, input logic [63:0] a,
                         input logic [63:0] b, input logic bin);
        if (w == 8) begin
            if8.start = st;
            if8.a     = a[7:0];
            if8.b     = b[7:0];
            if8.bin   = bin;
        end else begin
            if13.start = st;
            if13.a     = a[12:0];
            if13.b     = b[12:0];
            if13.bin   = bin;
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic void model(input int w, input longint unsigned a,
                                  input longint unsigned b, input bit bin,
                                  output longint unsigned d,
                                  output bit bo, output bit ov);
        longint unsigned mask;
        longint          half;
        longint          sa;
        longint          sb;
        longint          s;
        mask = (64'd1 << w) - 1;
        half = longint'(64'd1 << (w - 1));
        d    = (a - b - 64'(bin)) & mask;
        bo   = a < (b + 64'(bin));
        sa   = (longint'(a) >= half) ? longint'(a) - 2 * half : longint'(a);
        sb   = (longint'(b) >= half) ? longint'(b) - 2 * half : longint'(b);
        s    = sa - sb - longint'(bin);
        ov   = (s < -half) || (s > half - 1);
    endfunction

    // junk: 0 quiet, 1 random start/operands during op, 2 start FF-00 at E3
    task automatic run_op(input int w, input logic [63:0] a,
                          input logic [63:0] b, input logic bin,
                          input int junk, output logic [63:0] ad,
                          output logic ab, output logic ao);
        int k;
        int busy_n;
        bit hold_ok;
        int ix;
        ix = (w == 8) ? 0 : 1;
        @(negedge clk);
        drive(w, 1'b1, a, b, bin);
        @(negedge clk);
        k = 0;
        busy_n = 0;
        hold_ok = 1'b1;
        while (!g_done(w) && k <= w + 3) begin
            if (g_busy(w)) busy_n++;
            if (g_diff(w) !== prev_d[ix] || g_bout(w) !== prev_b[ix]
                || g_ovf(w) !== prev_o[ix]) hold_ok = 1'b0;
            if (junk == 1)
                drive(w, 1'($urandom), {$urandom, $urandom},
                      {$urandom, $urandom}, 1'($urandom));
            else if (junk == 2 && k == 2)
                drive(w, 1'b1, 64'hFF, 64'h00, 1'b0);
            else
                drive(w, 1'b0, a, b, bin);
            @(negedge clk);
            k++;
        end
        drive(w, 1'b0, a, b, bin);
        chk($sformatf("latency_w%0d", w), 64'(k), 64'(w));
        chk($sformatf("busy_cycles_w%0d", w), 64'(busy_n), 64'(w));
        chk($sformatf("hold_in_shift_w%0d", w), 64'(hold_ok), 64'd1);
        ad = g_diff(w);
        ab = g_bout(w);
        ao = g_ovf(w);
        prev_d[ix] = ad;
        prev_b[ix] = ab;
        prev_o[ix] = ao;
        @(negedge clk);
        chk($sformatf("done_pulse_w%0d", w), 64'(g_done(w)), 64'd0);
        chk($sformatf("busy_after_w%0d", w), 64'(g_busy(w)), 64'd0);
    endtask

    initial begin
        vec_t            tbl [8];
        logic [63:0]     ad;
        logic            ab;
        logic            ao;
        longint unsigned ed;
        bit              eb;
        bit              eo;
        int              dn;

        checks = 0;
        errors = 0;
        tbl[0] = '{8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0};
        tbl[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        tbl[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        tbl[3] = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        tbl[6] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[7] = '{8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1};

        rst_n = 1'b0;
        drive(8, 1'b1, 64'hAA, 64'h55, 1'b1);
        drive(13, 1'b1, 64'h1234, 64'h0F0F, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy8", 64'(if8.busy), 64'd0);
        chk("rst_done8", 64'(if8.done), 64'd0);
        chk("rst_diff8", 64'(if8.diff), 64'd0);
        chk("rst_bout8", 64'(if8.bout), 64'd0);
        chk("rst_ovf8", 64'(if8.ovf), 64'd0);
        chk("rst_busy13", 64'(if13.busy), 64'd0);
        chk("rst_diff13", 64'(if13.diff), 64'd0);
        drive(8, 1'b0, 0, 0, 1'b0);
        drive(13, 1'b0, 0, 0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            prev_d[i] = '0;
            prev_b[i] = 1'b0;
            prev_o[i] = 1'b0;
        end

        for (int i = 0; i < 8; i++) begin
            run_op(8, 64'(tbl[i].a), 64'(tbl[i].b), tbl[i].bin, 0,
                   ad, ab, ao);
            chk($sformatf("vec%0d_diff", i), ad, 64'(tbl[i].d));
            chk($sformatf("vec%0d_bout", i), 64'(ab), 64'(tbl[i].bo));
            chk($sformatf("vec%0d_ovf", i), 64'(ao), 64'(tbl[i].ov));
        end

        run_op(8, 64'h5A, 64'h23, 1'b0, 2, ad, ab, ao);
        chk("ignore_start_diff", ad, 64'h37);
        chk("ignore_start_bout", 64'(ab), 64'd0);

        @(negedge clk);
        drive(8, 1'b1, 64'h5A, 64'h23, 1'b0);
        @(negedge clk);
        drive(8, 1'b0, 64'h5A, 64'h23, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(if8.busy), 64'd0);
        chk("abort_done", 64'(if8.done), 64'd0);
        chk("abort_diff", 64'(if8.diff), 64'd0);
        chk("abort_bout", 64'(if8.bout), 64'd0);
        chk("abort_ovf", 64'(if8.ovf), 64'd0);
        rst_n = 1'b1;
        dn = 0;
        repeat (12) begin
            @(negedge clk);
            if (if8.done) dn++;
        end
        chk("abort_no_done", 64'(dn), 64'd0);
        for (int i = 0; i < 2; i++) begin
            prev_d[i] = '0;
            prev_b[i] = 1'b0;
            prev_o[i] = 1'b0;
        end
        run_op(8, 64'h00, 64'h01, 1'b0, 0, ad, ab, ao);
        chk("post_rst_diff", ad, 64'hFF);
        chk("post_rst_bout", 64'(ab), 64'd1);

        for (int i = 0; i < 2000; i++) begin
            int              w;
            longint unsigned ra;
            longint unsigned rb;
            bit              rbin;
            w    = (i < 1000) ? 8 : 13;
            ra   = 64'($urandom) & ((64'd1 << w) - 1);
            rb   = 64'($urandom) & ((64'd1 << w) - 1);
            rbin = 1'($urandom);
            model(w, ra, rb, rbin, ed, eb, eo);
            run_op(w, ra, rb, rbin, 1, ad, ab, ao);
            chk($sformatf("rnd%0d_diff", i), ad, ed);
            chk($sformatf("rnd%0d_bout", i), 64'(ab), 64'(eb));
            chk($sformatf("rnd%0d_ovf", i), 64'(ao), 64'(eo));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand and result width in bits; legal range 2..64.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have port start, input, 1, request to begin a subtraction; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH, minuend (unsigned); captured on the accepting edge.
REQ-006 The block SHALL have port b, input, WIDTH, subtrahend (unsigned); captured on the accepting edge.
REQ-007 The block SHALL have port bin, input, 1, borrow-in; captured on the accepting edge.
REQ-008 The block SHALL have port busy, output, 1, high while the operation is in progress (SHIFT state).
REQ-009 The block SHALL have port done, output, 1, one-cycle pulse marking a valid new result.
REQ-010 The block SHALL have port diff, output, WIDTH, registered difference.
REQ-011 The block SHALL have port bout, output, 1, registered final borrow-out.
REQ-012 The block SHALL have port ovf, output, 1, registered two's-complement overflow flag.

Function
REQ-013 The block SHALL implement states IDLE, SHIFT, DONE.
REQ-014 In IDLE with start=1, the block SHALL capture a, b and bin into internal shift and borrow registers, clear the bit counter, and enter SHIFT on that edge.
REQ-015 In IDLE with start=0, the block SHALL remain in IDLE and hold all outputs.
REQ-016 In SHIFT, each edge SHALL process one bit, LSB first, using d = a_i ^ b_i ^ br and br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br), where br is the borrow register.
REQ-017 In SHIFT, d SHALL be shifted into a WIDTH-bit result shift register from the MSB end, and br SHALL be updated to br_next.
REQ-018 SHIFT SHALL last exactly WIDTH edges; on the WIDTH-th edge the block SHALL enter DONE.
REQ-019 On that same edge, the block SHALL load diff with the completed result, load bout with the final br_next, and load ovf with (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]).
REQ-020 In DONE, done SHALL be 1 for exactly one cycle, and the block SHALL return to IDLE on the next edge.
REQ-021 The latency SHALL be WIDTH cycles: with start accepted at edge E0, done SHALL be high in the cycle following edge E_WIDTH.
REQ-022 The next start SHALL be accepted no earlier than edge E_(WIDTH+2).
REQ-023 busy SHALL be 1 exactly in SHIFT; it SHALL rise on the accepting edge and fall on the edge that enters DONE.
REQ-024 start SHALL be ignored in SHIFT and DONE; it has no effect on state or operands.
REQ-025 Changes on a, b or bin after the accepting edge SHALL NOT affect the in-flight result.
REQ-026 diff, bout and ovf SHALL hold their previous values throughout SHIFT, and SHALL change only on the edge that enters DONE.
REQ-027 The result SHALL satisfy diff = (a - b - bin) mod 2^WIDTH, with bout = 1 iff a < b + bin (unsigned comparison).
REQ-028 The bit counter SHALL be sized ceil(log2(WIDTH+1)) bits, and SHALL NOT wrap within an operation.

Reset
REQ-029 When rst_n=0 at a rising edge, the block SHALL enter IDLE and clear all of the following: busy, done, diff, bout, ovf, the bit counter, the shift registers and the borrow register.
REQ-030 Reset SHALL override start and SHALL abort any in-flight operation without asserting done.
REQ-031 After reset, the first start sampled with rst_n=1 SHALL be accepted normally.

Verification (WIDTH=8)
REQ-032 a=0x5A, b=0x23, bin=0, start pulse -> done high 8 cycles later; diff=0x37, bout=0, ovf=0.
REQ-033 a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1, ovf=0.
REQ-034 a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1; a=0x10, b=0x10, bin=1 -> diff=0xFF, bout=1, ovf=0.
REQ-035 Start 0x5A-0x23, then start pulsed with a=0xFF, b=0x00 at cycle 3 -> ignored; single done pulse with diff=0x37; busy high exactly 8 cycles.
REQ-036 rst_n low at cycle 4 of an operation -> IDLE next edge, all outputs 0, no done pulse; a subsequent start 0x00-0x01 yields diff=0xFF, bout=1.
REQ-037 A randomized bench of 1000 operations at WIDTH=8 and WIDTH=13, checked against a reference model -> all diff, bout and ovf values match; exactly one done pulse per accepted start.
